fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'd0, SHALL set the program counter value loaded on reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port mem_addr, output, 8 bits, SHALL be the program memory address; memory returns data combinationally in the same cycle.
REQ-005 Port mem_data, input, 8 bits, SHALL carry the program memory read data for mem_addr.
REQ-006 Port instr_valid, output, 1 bit, SHALL indicate that a complete instruction is presented.
REQ-007 Port instr_ready, input, 1 bit, SHALL be asserted by execute to accept the instruction.
REQ-008 Port instr_op, output, 8 bits, SHALL carry the opcode byte.
REQ-009 Port instr_arg, output, 8 bits, SHALL carry the operand byte, or 0 for no-operand opcodes.
REQ-010 Port instr_pc, output, 8 bits, SHALL carry the address of the opcode byte.
REQ-011 Ports resolve_valid, input, 1 bit; resolve_taken, input, 1 bit; resolve_addr, input, 8 bits, SHALL report the outcome of the outstanding control-flow instruction.
REQ-012 Port halted, output, 1 bit, SHALL be high once FIN has been accepted.

Function
REQ-013 The FSM SHALL have the states S_OP, S_ARG, S_OUT, S_WAIT and S_HALT.
REQ-014 In S_OP: mem_addr = pc; latch op_q <= mem_data; pc <= pc+1; go to S_ARG if the opcode has an operand, else clear arg_q to 0 and go to S_OUT.
REQ-015 Operand opcodes SHALL be exactly PSI(13), PSH(14), STR(15), JMP(20), JPZ(21), JPN(22), CAL(23) and CAR(25); all other byte values, including NUL(27) and 28-255, are no-operand.
REQ-016 In S_ARG: mem_addr = pc; latch arg_q <= mem_data; pc <= pc+1; go to S_OUT.
REQ-017 In S_OUT, instr_valid SHALL be 1, and instr_op, instr_arg and instr_pc SHALL hold stable until a cycle with instr_ready = 1.
REQ-018 On acceptance, FIN(26) SHALL go to S_HALT.
REQ-019 On acceptance, opcodes 20-25 SHALL go to S_WAIT.
REQ-020 On acceptance, all other opcodes SHALL go to S_OP.
REQ-021 In S_WAIT, instr_valid = 0 and no fetch occurs.
REQ-022 In S_WAIT, resolve_valid with resolve_taken = 1 SHALL load pc <= resolve_addr and go to S_OP.
REQ-023 In S_WAIT, resolve_valid with resolve_taken = 0 SHALL keep pc and go to S_OP.
REQ-024 resolve_* SHALL be ignored in every state other than S_WAIT.
REQ-025 S_HALT SHALL be terminal until reset: halted = 1, instr_valid = 0, pc frozen.
REQ-026 pc arithmetic SHALL be modulo 256: 255+1 wraps to 0, so an operand opcode at 255 takes its operand from address 0.
REQ-027 Latency from entering S_OP to instr_valid SHALL be 1 cycle for no-operand opcodes and 2 cycles for operand opcodes.
REQ-028 mem_addr SHALL equal pc in S_OUT, S_WAIT and S_HALT, a don't-care for memory that keeps the output glitch-free.

Reset
REQ-029 While rst_n = 0: state = S_OP, pc = RESET_PC, op_q = 0, arg_q = 0, instr_valid = 0, halted = 0, mem_addr = RESET_PC.
REQ-030 Reset asserted mid-instruction, including in S_OUT with an unaccepted instruction, SHALL discard all in-flight state immediately and asynchronously.
REQ-031 After reset is released, the first fetch SHALL occur on the first rising clk edge.

Structure
REQ-032 Opcode constants 0-27, the FSM state enum typedef, and a has_operand function SHALL live in shared package stack_machine_pkg, which the memory, execute and fetch blocks all import.
REQ-033 fetch_unit SHALL be a single module with no sub-modules; the stack and ALU stay in the execute stage.

Verification
REQ-034 Reset, then program PSI 10, PSI 20, ADD with instr_ready = 1 -> (op 13, arg 10, pc 0), then (13, 20, pc 2), then (0, 0, pc 4); first valid in the 2nd cycle after release.
REQ-035 Hold instr_ready = 0 for 5 cycles during PSI 10 -> outputs stable, pc stays at 2, no new fetch; accepted on the 6th cycle.
REQ-036 JPN 21 at pc 15, then resolve_taken = 1 with addr 21 after 3 cycles -> instr_valid low for those 3 cycles; next instruction is op 13 (PSI) at pc 21.
REQ-037 JPZ 0 at pc 8 with resolve_taken = 0 -> next instruction is fetched from pc 10; resolve pulses sent while in S_OUT are ignored.
REQ-038 PSI at address 255 with byte 7 at address 0 -> (op 13, arg 7, pc 255); next fetch from address 1.
REQ-039 FIN accepted -> halted = 1 and instr_valid stays 0 for 20 cycles; rst_n pulsed low mid-S_ARG -> pc = RESET_PC and halted = 0 asynchronously.

Source files
------------

// File: rtl/stack_machine_pkg.sv
// Shared stack-machine definitions: opcodes,
// fetch FSM states and operand decoding.
package stack_machine_pkg;

  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_MUL = 8'd2;
  localparam logic [7:0] OP_DIV = 8'd3;
  localparam logic [7:0] OP_MOD = 8'd4;
  localparam logic [7:0] OP_AND = 8'd5;
  localparam logic [7:0] OP_OR  = 8'd6;
  localparam logic [7:0] OP_XOR = 8'd7;
  localparam logic [7:0] OP_NOT = 8'd8;
  localparam logic [7:0] OP_NEG = 8'd9;
  localparam logic [7:0] OP_SHL = 8'd10;
  localparam logic [7:0] OP_SHR = 8'd11;
  localparam logic [7:0] OP_CMP = 8'd12;
  localparam logic [7:0] OP_PSI = 8'd13;
  localparam logic [7:0] OP_PSH = 8'd14;
  localparam logic [7:0] OP_STR = 8'd15;
  localparam logic [7:0] OP_LOD = 8'd16;
  localparam logic [7:0] OP_DUP = 8'd17;
  localparam logic [7:0] OP_DRP = 8'd18;
  localparam logic [7:0] OP_SWP = 8'd19;
  localparam logic [7:0] OP_JMP = 8'd20;
  localparam logic [7:0] OP_JPZ = 8'd21;
  localparam logic [7:0] OP_JPN = 8'd22;
  localparam logic [7:0] OP_CAL = 8'd23;
  localparam logic [7:0] OP_RET = 8'd24;
  localparam logic [7:0] OP_CAR = 8'd25;
  localparam logic [7:0] OP_FIN = 8'd26;
  localparam logic [7:0] OP_NUL = 8'd27;

  typedef enum logic [2:0] {
    S_OP,
    S_ARG,
    S_OUT,
    S_WAIT,
    S_HALT
  } fetch_state_e;

  function automatic logic has_operand(
    input logic [7:0] op
  );
    case (op)
      OP_PSI, OP_PSH, OP_STR,
      OP_JMP, OP_JPZ, OP_JPN,
      OP_CAL, OP_CAR: has_operand = 1'b1;
      default:        has_operand = 1'b0;
    endcase
  endfunction

  function automatic logic is_ctrl(
    input logic [7:0] op
  );
    is_ctrl = (op >= OP_JMP) && (op <= OP_CAR);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: program memory port, instruction
// handshake to execute and branch resolution.
interface fetch_unit_if;
  import stack_machine_pkg::*;

  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [7:0] instr_arg;
  logic [7:0] instr_pc;
  logic       resolve_valid;
  logic       resolve_taken;
  logic [7:0] resolve_addr;
  logic       halted;

  modport master (
    output mem_addr,
    input  mem_data,
    output instr_valid,
    input  instr_ready,
    output instr_op,
    output instr_arg,
    output instr_pc,
    input  resolve_valid,
    input  resolve_taken,
    input  resolve_addr,
    output halted
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  instr_valid,
    output instr_ready,
    input  instr_op,
    input  instr_arg,
    input  instr_pc,
    output resolve_valid,
    output resolve_taken,
    output resolve_addr,
    input  halted
  );

endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles
// opcode+operand, stalls on control flow.
module fetch_unit
  import stack_machine_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   op_q, op_d;
  logic [7:0]   arg_q, arg_d;
  logic [7:0]   ipc_q, ipc_d;

  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = (state_q == S_OUT);
  assign bus.instr_op    = op_q;
  assign bus.instr_arg   = arg_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.halted      = (state_q == S_HALT);

  // Next-state and datapath for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    arg_d   = arg_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      S_OP: begin
        op_d  = bus.mem_data;
        ipc_d = pc_q;
        pc_d  = pc_q + 8'd1;
        if (has_operand(bus.mem_data)) begin
          state_d = S_ARG;
        end else begin
          arg_d   = 8'd0;
          state_d = S_OUT;
        end
      end
      S_ARG: begin
        arg_d   = bus.mem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.instr_ready) begin
          if (op_q == OP_FIN)
            state_d = S_HALT;
          else if (is_ctrl(op_q))
            state_d = S_WAIT;
          else
            state_d = S_OP;
        end
      end
      S_WAIT: begin
        if (bus.resolve_valid) begin
          if (bus.resolve_taken)
            pc_d = bus.resolve_addr;
          state_d = S_OP;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_OP;
      end
    endcase
  end

  // State registers; reset drops any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OP;
      pc_q    <= RESET_PC;
      op_q    <= 8'd0;
      arg_q   <= 8'd0;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a
// behavioural program memory.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(8'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = mem[bus.mem_addr];

  typedef struct {
    int op;
    int arg;
    int pc;
    int lat;
    int stall;
    int ign;
    int wn;
    int taken;
    int raddr;
    int nxt;
  } vec_t;

  vec_t t1 [14];
  vec_t t2 [5];

  function automatic vec_t mk(
    int op, int arg, int pc, int lat, int stall,
    int ign, int wn, int taken, int raddr, int nxt
  );
    vec_t v;
    v.op = op; v.arg = arg; v.pc = pc;
    v.lat = lat; v.stall = stall; v.ign = ign;
    v.wn = wn; v.taken = taken; v.raddr = raddr;
    v.nxt = nxt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.instr_valid && n < 12) begin
      tick();
      n++;
    end
    if (!bus.instr_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: got 0 want 1");
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    wait_valid(n);
    chk("latency", n, v.lat);
    chk("op", int'(bus.instr_op), v.op);
    chk("arg", int'(bus.instr_arg), v.arg);
    chk("pc", int'(bus.instr_pc), v.pc);
    for (int i = 0; i < v.stall; i++) begin
      tick();
      chk("stall_valid", int'(bus.instr_valid), 1);
      chk("stall_op", int'(bus.instr_op), v.op);
      chk("stall_arg", int'(bus.instr_arg), v.arg);
      chk("stall_addr", int'(bus.mem_addr), v.nxt);
    end
    if (v.ign != 0) begin
      bus.resolve_valid = 1'b1;
      bus.resolve_taken = 1'b1;
      bus.resolve_addr  = 8'hAA;
      tick();
      tick();
      bus.resolve_valid = 1'b0;
      chk("ign_valid", int'(bus.instr_valid), 1);
      chk("ign_addr", int'(bus.mem_addr), v.nxt);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    if (v.op >= 20 && v.op <= 25) begin
      for (int i = 0; i < v.wn; i++) begin
        chk("wait_valid", int'(bus.instr_valid), 0);
        chk("wait_addr", int'(bus.mem_addr), v.nxt);
        tick();
      end
      bus.resolve_valid = 1'b1;
      bus.resolve_taken = v.taken[0];
      bus.resolve_addr  = v.raddr[7:0];
      tick();
      bus.resolve_valid = 1'b0;
      bus.resolve_taken = 1'b0;
    end
    if (v.op == 26) begin
      bus.resolve_valid = 1'b1;
      bus.resolve_taken = 1'b1;
      bus.resolve_addr  = 8'h55;
      for (int i = 0; i < 20; i++) begin
        chk("halt_flag", int'(bus.halted), 1);
        chk("halt_valid", int'(bus.instr_valid), 0);
        chk("halt_addr", int'(bus.mem_addr), v.nxt);
        tick();
      end
      bus.resolve_valid = 1'b0;
      bus.resolve_taken = 1'b0;
    end
  endtask

  initial begin
    t1[0]  = mk(13, 10,  0, 2, 5, 0, 0, 0,  0,  2);
    t1[1]  = mk(13, 20,  2, 2, 0, 0, 0, 0,  0,  4);
    t1[2]  = mk( 0,  0,  4, 1, 0, 0, 0, 0,  0,  5);
    t1[3]  = mk(15,  5,  5, 2, 0, 0, 0, 0,  0,  7);
    t1[4]  = mk(27,  0,  7, 1, 0, 0, 0, 0,  0,  8);
    t1[5]  = mk(21,  0,  8, 2, 0, 1, 2, 0,  0, 10);
    t1[6]  = mk(13,  1, 10, 2, 0, 0, 0, 0,  0, 12);
    t1[7]  = mk(17,  0, 12, 1, 0, 0, 0, 0,  0, 13);
    t1[8]  = mk(200, 0, 13, 1, 0, 0, 0, 0,  0, 14);
    t1[9]  = mk(255, 0, 14, 1, 0, 0, 0, 0,  0, 15);
    t1[10] = mk(22, 21, 15, 2, 0, 0, 3, 1, 21, 17);
    t1[11] = mk(13, 66, 21, 2, 0, 0, 0, 0,  0, 23);
    t1[12] = mk(24,  0, 23, 1, 0, 0, 1, 1, 40, 24);
    t1[13] = mk(26,  0, 40, 1, 0, 0, 0, 0,  0, 41);

    t2[0] = mk( 7,   0,   0, 1, 0, 0, 0, 0,   0, 1);
    t2[1] = mk(20, 255,   1, 2, 0, 0, 1, 1, 255, 3);
    t2[2] = mk(13,   7, 255, 2, 0, 0, 0, 0,   0, 1);
    t2[3] = mk(20, 255,   1, 2, 0, 0, 0, 0,   0, 3);
    t2[4] = mk(26,   0,   3, 1, 0, 0, 0, 0,   0, 4);

    for (int i = 0; i < 256; i++) mem[i] = 8'd27;
    mem[0] = 8'd13;  mem[1] = 8'd10;
    mem[2] = 8'd13;  mem[3] = 8'd20;
    mem[4] = 8'd0;   mem[5] = 8'd15;
    mem[6] = 8'd5;   mem[7] = 8'd27;
    mem[8] = 8'd21;  mem[9] = 8'd0;
    mem[10] = 8'd13; mem[11] = 8'd1;
    mem[12] = 8'd17; mem[13] = 8'd200;
    mem[14] = 8'd255; mem[15] = 8'd22;
    mem[16] = 8'd21; mem[21] = 8'd13;
    mem[22] = 8'd66; mem[23] = 8'd24;
    mem[40] = 8'd26;

    bus.instr_ready   = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.resolve_addr  = 8'd0;

    tick();
    tick();
    chk("rst_valid", int'(bus.instr_valid), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_op", int'(bus.instr_op), 0);
    chk("rst_arg", int'(bus.instr_arg), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(t1[i]);

    rst_n = 1'b0;
    #1;
    chk("async_halt_clr", int'(bus.halted), 0);
    chk("async_addr", int'(bus.mem_addr), 0);
    mem[0] = 8'd7;   mem[1] = 8'd20;
    mem[2] = 8'd255; mem[3] = 8'd26;
    mem[255] = 8'd13;
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(t2[i]);

    rst_n = 1'b0;
    #1;
    chk("async2_halt_clr", int'(bus.halted), 0);
    mem[0] = 8'd14;
    tick();
    rst_n = 1'b1;
    tick();
    chk("in_arg_addr", int'(bus.mem_addr), 1);
    chk("in_arg_valid", int'(bus.instr_valid), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_arg_addr", int'(bus.mem_addr), 0);
    chk("mid_arg_op", int'(bus.instr_op), 0);
    chk("mid_arg_valid", int'(bus.instr_valid), 0);
    chk("mid_arg_halted", int'(bus.halted), 0);
    tick();
    rst_n = 1'b1;
    run_vec(mk(14, 20, 0, 2, 0, 0, 0, 0, 0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
